// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates D-miss, redirect, load-use, I-miss.
// Optional build macro PIPE_HAZARD_PERF_EN adds saturating load-use / miss event counters.
module pipe_hazard_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ic_stall_i,
  input  logic            dc_stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            idex_memread_i,
  input  logic [4:0]      idex_rd_i,
  input  logic [4:0]      ifid_rs1_i,
  input  logic [4:0]      ifid_rs2_i,
  output logic            pc_stall_o,
  output logic            pc_load_o,
  output logic [XLEN-1:0] pc_tgt_o,
  output logic            ifid_stall_o,
  output logic            ifid_flush_o,
  output logic            idex_stall_o,
  output logic            idex_flush_o,
  output logic            exmem_stall_o,
`ifdef PIPE_HAZARD_PERF_EN
  output logic            memwb_stall_o,
  output logic [31:0]     lu_cnt_o,
  output logic [31:0]     miss_cnt_o
`else
  output logic            memwb_stall_o
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    IMISS    = 2'd1,
    IMISS_SQ = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            lu;
  logic            lu_fire;

  assign lu = idex_memread_i && (idex_rd_i != 5'd0) &&
              ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));

  // Load-use only takes effect when nothing of higher priority claims the cycle.
  assign lu_fire = !dc_stall_i && !redirect_i && (state_q != IMISS_SQ) && lu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    if (dc_stall_i) begin
      state_d = state_q;
    end else if (redirect_i) begin
      if (ic_stall_i) begin
        state_d = IMISS_SQ;
        tgt_d   = redirect_pc_i;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == IMISS_SQ) begin
      state_d = ic_stall_i ? IMISS_SQ : RUN;
    end else if (lu) begin
      state_d = ic_stall_i ? IMISS : RUN;
    end else if (ic_stall_i) begin
      state_d = IMISS;
    end else begin
      state_d = RUN;
    end
  end

  always_comb begin
    pc_stall_o    = 1'b0;
    pc_load_o     = 1'b0;
    pc_tgt_o      = '0;
    ifid_stall_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_stall_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_stall_o = 1'b0;
    memwb_stall_o = 1'b0;
    if (rst) begin
      pc_stall_o = 1'b0;
    end else if (dc_stall_i) begin
      pc_stall_o    = 1'b1;
      ifid_stall_o  = 1'b1;
      idex_stall_o  = 1'b1;
      exmem_stall_o = 1'b1;
      memwb_stall_o = 1'b1;
    end else if (redirect_i) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      if (ic_stall_i) begin
        pc_stall_o = 1'b1;
      end else begin
        pc_load_o = 1'b1;
        pc_tgt_o  = redirect_pc_i;
      end
    end else if (state_q == IMISS_SQ) begin
      // Wrong-path fetch is squashed until the miss retires, then the saved target is applied.
      ifid_flush_o = 1'b1;
      if (ic_stall_i) begin
        pc_stall_o = 1'b1;
      end else begin
        pc_load_o = 1'b1;
        pc_tgt_o  = tgt_q;
      end
    end else if (lu) begin
      pc_stall_o   = 1'b1;
      ifid_stall_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (ic_stall_i) begin
      pc_stall_o   = 1'b1;
      ifid_flush_o = 1'b1;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_cnt_o   <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (lu_fire) lu_cnt_o <= sat_inc(lu_cnt_o);
      if (dc_stall_i || ic_stall_i) miss_cnt_o <= sat_inc(miss_cnt_o);
    end
  end
`else
  logic unused_lu_fire;
  assign unused_lu_fire = lu_fire;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver queues expected outputs per cycle, monitor compares.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_stall_i, dc_stall_i, redirect_i, idex_memread_i;
  logic [31:0] redirect_pc_i;
  logic [4:0]  idex_rd_i, ifid_rs1_i, ifid_rs2_i;
  logic        pc_stall_o, pc_load_o, ifid_stall_o, ifid_flush_o;
  logic        idex_stall_o, idex_flush_o, exmem_stall_o, memwb_stall_o;
  logic [31:0] pc_tgt_o;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] lu_cnt_o, miss_cnt_o;
`endif

  pipe_hazard_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .ic_stall_i(ic_stall_i), .dc_stall_i(dc_stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
    .ifid_rs1_i(ifid_rs1_i), .ifid_rs2_i(ifid_rs2_i),
    .pc_stall_o(pc_stall_o), .pc_load_o(pc_load_o), .pc_tgt_o(pc_tgt_o),
    .ifid_stall_o(ifid_stall_o), .ifid_flush_o(ifid_flush_o),
    .idex_stall_o(idex_stall_o), .idex_flush_o(idex_flush_o),
    .exmem_stall_o(exmem_stall_o),
`ifdef PIPE_HAZARD_PERF_EN
    .memwb_stall_o(memwb_stall_o),
    .lu_cnt_o(lu_cnt_o), .miss_cnt_o(miss_cnt_o)
`else
    .memwb_stall_o(memwb_stall_o)
`endif
  );

  always #5 clk = ~clk;

  // {pc_stall, pc_load, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_stall}
  localparam logic [7:0] IDLE   = 8'b0000_0000;
  localparam logic [7:0] DSTALL = 8'b1010_1011;
  localparam logic [7:0] LU     = 8'b1010_0100;
  localparam logic [7:0] RLOAD  = 8'b0101_0100;
  localparam logic [7:0] RMISS  = 8'b1001_0100;
  localparam logic [7:0] MISS   = 8'b1001_0000;
  localparam logic [7:0] SQLOAD = 8'b0101_0000;

  typedef struct {
    string       name;
    logic [7:0]  ctl;
    logic [31:0] tgt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   drv_done = 1'b0;
  int   cycles = 0;

  task automatic set_in(input logic ic, input logic dc, input logic rd,
                        input logic [31:0] rpc, input logic mr, input logic [4:0] exrd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
    ic_stall_i = ic; dc_stall_i = dc; redirect_i = rd; redirect_pc_i = rpc;
    idex_memread_i = mr; idex_rd_i = exrd; ifid_rs1_i = rs1; ifid_rs2_i = rs2;
  endtask

  // Push the expected response for the inputs just applied, then advance one cycle.
  task automatic expect_cyc(input string nm, input logic [7:0] ctl, input logic [31:0] tgt);
    exp_t e;
    e.name = nm; e.ctl = ctl; e.tgt = tgt;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input string nm);
    set_in(0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    expect_cyc(nm, IDLE, 32'h0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {pc_stall_o, pc_load_o, ifid_stall_o, ifid_flush_o,
               idex_stall_o, idex_flush_o, exmem_stall_o, memwb_stall_o};
        checks++;
        if (act !== e.ctl || pc_tgt_o !== e.tgt) begin
          errors++;
          $display("FAIL %s: got ctl=%b tgt=%h, want ctl=%b tgt=%h",
                   e.name, act, pc_tgt_o, e.ctl, e.tgt);
        end
      end
    end
  end

  // Watchdog
  always @(posedge clk) begin
    cycles++;
    if (cycles > 5000 && !drv_done) begin
      $display("FAIL watchdog: got %0d cycles, want under 5000", cycles);
      $fatal(1, "timeout");
    end
  end

  // Driver
  initial begin
    rst = 1'b1;
    set_in(1, 0, 1, 32'hDEAD_0000, 1, 5'd3, 5'd3, 5'd0);
    @(posedge clk); #1;
    expect_cyc("reset_forces_zero", IDLE, 32'h0);
    rst = 1'b0;
    idle("after_reset");

    set_in(0, 0, 0, 32'h0, 1, 5'd5, 5'd1, 5'd5);
    expect_cyc("lu_rs2", LU, 32'h0);
    idle("lu_one_bubble");
    set_in(0, 0, 0, 32'h0, 1, 5'd0, 5'd0, 5'd0);
    expect_cyc("lu_rd_zero", IDLE, 32'h0);
    set_in(0, 0, 0, 32'h0, 1, 5'd7, 5'd7, 5'd2);
    expect_cyc("lu_rs1", LU, 32'h0);
    set_in(0, 0, 0, 32'h0, 0, 5'd7, 5'd7, 5'd7);
    expect_cyc("no_load_no_lu", IDLE, 32'h0);

    set_in(0, 0, 1, 32'h100, 0, 5'd0, 5'd0, 5'd0);
    expect_cyc("redirect_nomiss", RLOAD, 32'h100);
    idle("after_redirect");

    set_in(1, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    expect_cyc("miss_c1", MISS, 32'h0);
    set_in(1, 0, 1, 32'h200, 0, 5'd0, 5'd0, 5'd0);
    expect_cyc("miss_c2_redirect", RMISS, 32'h0);
    set_in(1, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    expect_cyc("sq_c3", MISS, 32'h0);
    expect_cyc("sq_c4", MISS, 32'h0);
    set_in(0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    expect_cyc("sq_load", SQLOAD, 32'h200);
    idle("after_sq_load");

    set_in(1, 0, 1, 32'h300, 0, 5'd0, 5'd0, 5'd0);
    expect_cyc("dc_ov_redirect", RMISS, 32'h0);
    set_in(1, 1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    expect_cyc("dc_ov_c1", DSTALL, 32'h0);
    set_in(0, 1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    expect_cyc("dc_ov_c2", DSTALL, 32'h0);
    expect_cyc("dc_ov_c3", DSTALL, 32'h0);
    set_in(0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    expect_cyc("dc_ov_load", SQLOAD, 32'h300);
    idle("after_dc_ov");

    set_in(1, 0, 1, 32'h400, 0, 5'd0, 5'd0, 5'd0);
    expect_cyc("latest_r1", RMISS, 32'h0);
    set_in(1, 0, 1, 32'h500, 0, 5'd0, 5'd0, 5'd0);
    expect_cyc("latest_r2", RMISS, 32'h0);
    set_in(0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    expect_cyc("latest_wins", SQLOAD, 32'h500);

    set_in(1, 0, 1, 32'h600, 0, 5'd0, 5'd0, 5'd0);
    expect_cyc("rst_sq_enter", RMISS, 32'h0);
    rst = 1'b1;
    set_in(1, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    expect_cyc("rst_mid_sq", IDLE, 32'h0);
    set_in(0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    expect_cyc("rst_held", IDLE, 32'h0);
    rst = 1'b0;
    idle("rst_no_load");
    set_in(1, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    expect_cyc("plain_miss", MISS, 32'h0);
    idle("plain_miss_done");

    set_in(0, 0, 1, 32'h700, 1, 5'd4, 5'd4, 5'd0);
    expect_cyc("redirect_over_lu", RLOAD, 32'h700);
    set_in(1, 0, 0, 32'h0, 1, 5'd9, 5'd0, 5'd9);
    expect_cyc("lu_over_miss", LU, 32'h0);
    set_in(1, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    expect_cyc("miss_after_lu", MISS, 32'h0);
    set_in(0, 1, 1, 32'h800, 1, 5'd4, 5'd4, 5'd0);
    expect_cyc("dc_over_redirect", DSTALL, 32'h0);
    idle("final_idle");

`ifdef PIPE_HAZARD_PERF_EN
    rst = 1'b1;
    set_in(0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    expect_cyc("perf_reset", IDLE, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 32'h0, 1, 5'd6, 5'd6, 5'd0);
      expect_cyc("perf_lu", LU, 32'h0);
      idle("perf_gap");
    end
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
      expect_cyc("perf_miss", MISS, 32'h0);
    end
    idle("perf_end");
    checks++;
    if (lu_cnt_o !== 32'd3) begin
      errors++;
      $display("FAIL lu_cnt: got %0d, want 3", lu_cnt_o);
    end
    checks++;
    if (miss_cnt_o !== 32'd5) begin
      errors++;
      $display("FAIL miss_cnt: got %0d, want 5", miss_cnt_o);
    end
`endif

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    drv_done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
